imem_fetch_queue: RTL and testbench
===================================

Name: imem_fetch_queue

Overview:
- Byte-addressed, little-endian instruction memory with a synchronous read port, a byte-wide programming port, and a prefetch FIFO.
- Sits between the PC logic and IF/ID. It fetches sequentially from an internal fetch PC and presents {pc, instr, fault} to the pipeline over a valid/ready handshake.
- A branch redirect flushes all wrong-path state.

Parameters:
- MEM_BYTES, 256, memory size in bytes; multiple of 4, minimum 8.
- ADDR_W, 64, address width.
- FIFO_DEPTH, 4, prefetch entries; power of 2, minimum 2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  reset; one clock, synchronous and active-high.
- prog_we  in  1  byte write enable.
- prog_addr  in  ADDR_W  byte write address; ignored if >= MEM_BYTES.
- prog_data  in  8  byte to write.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head entry.
- out_pc  out  ADDR_W  PC of the head entry.
- out_instr  out  32  instruction; bits [7:0] come from the byte at pc.
- out_fault  out  1  head entry was misaligned or out of range.

Behaviour:
- Reset:
  - fetch_pc = RESET_PC; FIFO empty; in-flight read killed.
  - out_valid = 0, out_pc = 0, out_instr = 0, out_fault = 0.
  - Memory contents are not cleared by reset. Memory is zero at time 0.
- Reset mid-operation: the reset rules above take effect in the cycle after reset is sampled high. Memory is preserved.
- Read pipeline:
  - Issue stage reads 4 bytes at fetch_pc; data is registered into the in-flight stage (infl_valid, pc, word, fault).
  - Next cycle the in-flight entry is pushed into the FIFO.
- Issue condition: !reset && !redirect_valid && (count - pop + infl_valid) < FIFO_DEPTH.
  - pop = out_valid && out_ready && !redirect_valid.
  - On issue: fetch_pc += 4 (wraps modulo 2^ADDR_W).
- Credit accounting guarantees no overflow. Sustained rate is 1 instr/cycle with out_ready held high.
- Latency:
  - From the first cycle reset is low, or the cycle after redirect: issue in cycle 0, FIFO push at edge 1, out_valid high in cycle 2.
  - out_valid rises on the 2nd rising edge after reset is sampled low.
- FIFO is show-ahead. All out_* signals are driven from the head entry and stay stable while out_valid && !out_ready.
- Fault:
  - Set when fetch_pc[1:0] != 0 or fetch_pc > MEM_BYTES-4.
  - The entry then carries instr = NOP (0x00000013) and fault = 1; no memory access is made.
  - Fetching continues at pc+4; the consumer decides to trap.
- Redirect, in the cycle redirect_valid is high:
  - FIFO cleared and in-flight entry killed at the edge.
  - fetch_pc <= redirect_pc.
  - No issue that cycle.
  - Any handshake in that cycle is discarded: no pop, and the entry is treated as wrong-path.
  - Redirect on consecutive cycles: the last one wins.
- Programming:
  - Write occurs at the edge.
  - A read of the same byte in the same cycle returns the old data (read-before-write).
  - Entries already in the FIFO or in flight are not updated. Software must redirect after programming.
- reset has priority over redirect_valid, which has priority over issue.
- FIFO full with out_ready = 0: no issue, fetch_pc holds, no entry lost or duplicated.
- FIFO empty: out_valid = 0; out_pc, out_instr and out_fault are don't-care.

Decomposition:
- Package imem_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - typedef instr_t (logic [31:0]).
  - typedef struct fetch_entry_t {pc, instr, fault}, parametrised by ADDR_W via package parameter 64.
- Sub-module fetch_fifo:
  - Synchronous show-ahead FIFO of fetch_entry_t with ports push, pop, clear, count, head.
  - reset and clear are synchronous.
- Top level holds memory, fetch_pc, the in-flight register, and the issue/credit logic.

Test Plan:
- Sequential fetch:
  - Program bytes B3 00 21 00 at 0..3 and 23 26 10 00 at 4..7; reset; out_ready = 1.
  - Expect out_valid in the 2nd cycle after reset, then pc 0 / 0x002100B3, then pc 4 / 0x00102623 on consecutive cycles, with fault = 0.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles.
  - Expect the head to hold at pc 0 and count to saturate at FIFO_DEPTH.
  - On release, expect pcs 0, 4, 8, 12 back-to-back with no gaps or duplicates.
- Redirect while FIFO is full, redirect_pc = 0x8 and out_ready = 1 in the same cycle:
  - Expect no pop and out_valid = 0 for 2 cycles.
  - Then expect pc 8 followed by pc 12.
- Misalignment and range:
  - Redirect to 0x6: expect pc 6, fault = 1, instr 0x00000013, then pc 0xA with fault = 1.
  - MEM_BYTES = 64: pc 60 gives fault = 0; pc 64 gives fault = 1 / NOP.
- Program collision:
  - prog_we to byte 0 in the same cycle that pc 0 is issued: the delivered instr holds the old byte.
  - After redirect to 0, the new byte appears.
- Mid-operation reset with 3 entries queued:
  - Expect out_valid = 0 the next cycle and a restart at RESET_PC.
  - Memory bytes must be unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory fetch queue.
package imem_pkg;

   localparam int PKG_ADDR_W = 64;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [31:0] instr_t;

   typedef struct packed {
      logic [PKG_ADDR_W-1:0] pc;
      instr_t                instr;
      logic                  fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries.
module fetch_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  fetch_entry_t i_data,
   input  logic         i_pop,
   input  logic         i_clear,
   output logic [PTR_W:0] o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W:0]   r_count;

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop) r_rd <= r_rd + 1'b1;
         unique case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !reset && !i_clear) r_mem[r_wr] <= i_data;
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/imem_fetch_queue.sv
// Instruction memory with sequential prefetch into a show-ahead queue.
module imem_fetch_queue
   import imem_pkg::*;
#(
   parameter int MEM_BYTES  = 256,
   parameter int ADDR_W     = 64,
   parameter int FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [7:0]        prog_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic [31:0]       out_instr,
   output logic              out_fault
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = $clog2(MEM_BYTES);

   logic [7:0]        r_mem [MEM_BYTES] = '{default: 8'h00};
   logic [ADDR_W-1:0] r_pc;
   logic              r_infl_valid;
   fetch_entry_t      r_infl;

   logic [CNT_W-1:0]  w_count;
   fetch_entry_t      w_head;
   logic              w_valid;
   logic              w_pop;
   logic              w_issue;
   logic              w_fault;
   logic              w_push;
   logic [IDX_W-1:0]  w_idx;
   instr_t            w_word;

   always_comb begin
      w_fault = (r_pc[1:0] != 2'b00) ||
                (r_pc > ADDR_W'(MEM_BYTES - 4));
      w_idx   = r_pc[IDX_W-1:0];
      w_word  = {r_mem[w_idx + IDX_W'(3)], r_mem[w_idx + IDX_W'(2)],
                 r_mem[w_idx + IDX_W'(1)], r_mem[w_idx]};
   end

   assign w_valid = (w_count != '0);
   assign w_pop   = w_valid && out_ready && !redirect_valid;
   assign w_push  = r_infl_valid && !redirect_valid;

   // Credits cover both queued and in-flight entries, so a push never overflows.
   assign w_issue = !reset && !redirect_valid &&
      (int'(w_count) + int'(r_infl_valid) - int'(w_pop) < FIFO_DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc         <= RESET_PC;
         r_infl_valid <= 1'b0;
      end else if (redirect_valid) begin
         r_pc         <= redirect_pc;
         r_infl_valid <= 1'b0;
      end else begin
         r_infl_valid <= w_issue;
         if (w_issue) begin
            r_pc         <= r_pc + ADDR_W'(4);
            r_infl.pc    <= PKG_ADDR_W'(r_pc);
            r_infl.instr <= w_fault ? NOP_INSTR : w_word;
            r_infl.fault <= w_fault;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (prog_we && (prog_addr < ADDR_W'(MEM_BYTES)))
         r_mem[prog_addr[IDX_W-1:0]] <= prog_data;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (r_infl),
      .i_pop   (w_pop),
      .i_clear (redirect_valid),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign out_valid = w_valid;
   assign out_pc    = w_valid ? w_head.pc[ADDR_W-1:0] : '0;
   assign out_instr = w_valid ? w_head.instr : '0;
   assign out_fault = w_valid && w_head.fault;

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Bench for imem_fetch_queue: stream model plus directed literal checks.
module tb_imem_fetch_queue;
   import imem_pkg::*;

   localparam int MEM   = 64;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        prog_we;
   logic [63:0] prog_addr;
   logic [7:0]  prog_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_fault;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   imem_fetch_queue #(
      .MEM_BYTES  (MEM),
      .ADDR_W     (64),
      .FIFO_DEPTH (DEPTH),
      .RESET_PC   (64'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .prog_we        (prog_we),
      .prog_addr      (prog_addr),
      .prog_data      (prog_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_fault      (out_fault)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic head(input string nm, input logic [63:0] pc,
                       input logic [31:0] ins, input logic f);
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_pc"}, out_pc, pc);
      chk({nm, "_instr"}, 64'(out_instr), 64'(ins));
      chk({nm, "_fault"}, 64'(out_fault), 64'(f));
   endtask

   task automatic redir(input logic [63:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   // Stream model: after a restart the head must walk pc, pc+4, ...
   logic [7:0]  m_mem [MEM];
   bit          m_dirty [MEM];
   logic [63:0] exp_pc = '0;
   int          cyc = 0;
   bit          chk_en = 1'b0;
   bit          prev_valid = 1'b0;

   initial begin
      for (int i = 0; i < MEM; i++) begin
         m_mem[i]   = 8'h00;
         m_dirty[i] = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic        f;
      logic [31:0] w;
      bit          d;
      if (chk_en) begin
         if (cyc < 2) chk("m_lat_lo", 64'(out_valid), 64'd0);
         else if (cyc == 2) chk("m_lat_hi", 64'(out_valid), 64'd1);
         else if (prev_valid) chk("m_no_gap", 64'(out_valid), 64'd1);
         if (out_valid) begin
            chk("m_pc", out_pc, exp_pc);
            f = (exp_pc[1:0] != 2'b00) || (exp_pc > 64'(MEM - 4));
            chk("m_fault", 64'(out_fault), 64'(f));
            if (f) begin
               chk("m_nop", 64'(out_instr), 64'(NOP_INSTR));
            end else begin
               w = '0;
               d = 1'b0;
               for (int k = 0; k < 4; k++) begin
                  w[k*8 +: 8] = m_mem[int'(exp_pc) + k];
                  d = d | m_dirty[int'(exp_pc) + k];
               end
               if (!d) chk("m_instr", 64'(out_instr), 64'(w));
            end
            if (out_ready && !redirect_valid && !reset) exp_pc = exp_pc + 64'd4;
         end
      end
      prev_valid = out_valid;
      if (reset || redirect_valid) begin
         chk_en = 1'b1;
         cyc    = 0;
         exp_pc = reset ? 64'h0 : redirect_pc;
         for (int i = 0; i < MEM; i++) m_dirty[i] = 1'b0;
      end else if (cyc < 1000) begin
         cyc++;
      end
      if (prog_we && prog_addr < 64'(MEM)) begin
         m_mem[int'(prog_addr)] = prog_data;
         if (!(reset || redirect_valid)) m_dirty[int'(prog_addr)] = 1'b1;
      end
   end

   logic [7:0] init_b [8];

   initial begin
      init_b = '{8'hB3, 8'h00, 8'h21, 8'h00, 8'h23, 8'h26, 8'h10, 8'h00};
      reset = 1'b1;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b0;
      tick();
      for (int i = 0; i < MEM; i++) begin
         prog_we   = 1'b1;
         prog_addr = 64'(i);
         prog_data = (i < 8) ? init_b[i] : 8'(i * 7 + 5);
         tick();
      end
      prog_we = 1'b0;
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pc", out_pc, 64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_fault", 64'(out_fault), 64'd0);

      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("seq_c1_valid", 64'(out_valid), 64'd0);
      tick();
      head("seq0", 64'd0, 32'h002100B3, 1'b0);
      tick();
      head("seq4", 64'd4, 32'h00102623, 1'b0);

      reset = 1'b1;
      out_ready = 1'b0;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      head("bp_hold", 64'd0, 32'h002100B3, 1'b0);
      chk("bp_count", 64'(dut.w_count), 64'(DEPTH));
      out_ready = 1'b1;
      tick();
      chk("bp_pc4", out_pc, 64'd4);
      tick();
      head("bp_pc8", 64'd8, 32'h524B443D, 1'b0);
      tick();
      head("bp_pc12", 64'd12, 32'h6E676059, 1'b0);

      out_ready = 1'b0;
      repeat (6) tick();
      chk("rf_count", 64'(dut.w_count), 64'(DEPTH));
      out_ready = 1'b1;
      redir(64'd8);
      chk("rf_c0_valid", 64'(out_valid), 64'd0);
      tick();
      chk("rf_c1_valid", 64'(out_valid), 64'd0);
      tick();
      head("rf_pc8", 64'd8, 32'h524B443D, 1'b0);
      tick();
      chk("rf_pc12", out_pc, 64'd12);

      redirect_valid = 1'b1;
      redirect_pc = 64'd32;
      tick();
      redirect_pc = 64'd40;
      tick();
      redirect_valid = 1'b0;
      tick();
      tick();
      chk("rr_last_wins", out_pc, 64'd40);

      redir(64'd6);
      tick();
      tick();
      head("mis6", 64'd6, NOP_INSTR, 1'b1);
      tick();
      head("misA", 64'd10, NOP_INSTR, 1'b1);

      redir(64'd60);
      tick();
      tick();
      head("rng60", 64'd60, 32'hBEB7B0A9, 1'b0);
      tick();
      head("rng64", 64'd64, NOP_INSTR, 1'b1);

      redir(64'd0);
      prog_we = 1'b1;
      prog_addr = 64'd0;
      prog_data = 8'h5A;
      tick();
      prog_we = 1'b0;
      tick();
      head("col_old", 64'd0, 32'h002100B3, 1'b0);
      redir(64'd0);
      tick();
      tick();
      head("col_new", 64'd0, 32'h0021005A, 1'b0);

      out_ready = 1'b0;
      redir(64'd16);
      repeat (4) tick();
      chk("mr_count3", 64'(dut.w_count), 64'd3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_valid", 64'(out_valid), 64'd0);
      chk("mr_pc", out_pc, 64'd0);
      out_ready = 1'b1;
      tick();
      chk("mr_c1_valid", 64'(out_valid), 64'd0);
      tick();
      head("mr_pc0", 64'd0, 32'h0021005A, 1'b0);
      tick();
      head("mr_pc4", 64'd4, 32'h00102623, 1'b0);

      redir(64'd0);
      for (int i = 0; i < 40; i++) begin
         out_ready = (i % 3) != 0;
         tick();
      end
      out_ready = 1'b1;
      repeat (5) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
